dec_scan_n: RTL
===============

# dec_scan_n

Parametrised, registered N-to-2^N one-hot decoder with an autonomous scan mode, for driving multiplexed display digits and channel selects. In direct mode it registers the decode of an external index. In scan mode an internal prescaled counter walks the active channels cyclically and flags each step. Enable gating forces all outputs inactive. It sits between control logic (or a free-running system clock) and digit/anode enables.

## Interface
Parameters:
- N, default 2: index width; D is 2^N bits wide.
- CHANNELS, default 2**N: number of used channels, 1..2^N; indices at or above CHANNELS are never asserted.
- PRESCALE, default 4: clock cycles per scan step, ≥1.
- ACTIVE_LOW, default 0: 1 inverts D so the selected bit is 0 and inactive bits are 1.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  block enable; 0 forces D inactive.
- MODE  in  1  0 = direct (decode A), 1 = scan (internal counter).
- A  in  N  direct-mode index.
- D  out  2^N  registered one-hot decode (polarity per ACTIVE_LOW).
- SEL  out  N  index currently driven on D (scan counter in scan mode, registered A in direct mode).
- STEP  out  1  one-cycle pulse, scan mode only, high in the cycle a new scan index first appears on D.

## Operation
- States: IDLE, DIRECT, SCAN. The next state is set every edge from EN and MODE: EN=0 → IDLE, EN=1 and MODE=0 → DIRECT, EN=1 and MODE=1 → SCAN.
- Reset (asynchronous, immediate) sets:
  - state IDLE, SEL=0, prescaler=0, STEP=0;
  - D inactive: all 0, or all 1 when ACTIVE_LOW=1.
- IDLE:
  - D inactive, STEP=0, SEL holds its last value, prescaler cleared.
- DIRECT:
  - D = onehot(A) and SEL = A, registered.
  - If A ≥ CHANNELS, D is inactive and SEL = A.
  - STEP=0, prescaler held at 0.
- SCAN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - When the prescaler is at its terminal count, SEL advances by 1, wrapping from CHANNELS-1 to 0, and STEP pulses with the new D.
  - D is always onehot(SEL).
  - PRESCALE=1 advances SEL every cycle, so STEP stays high continuously.
  - CHANNELS=1: SEL stays 0 and STEP still pulses every PRESCALE cycles.
- Entering SCAN from IDLE or DIRECT:
  - SEL loaded with 0 and prescaler cleared.
  - D = onehot(0) on the first SCAN edge, with STEP=1 to mark step 0.
- Leaving SCAN: D follows the new state on the next edge; no partial step is completed.
- RST asserted mid-scan aborts immediately. After release, the block enters its mode on the first edge with EN=1.
- The prescaler width is max(1, $clog2(PRESCALE)). The SEL increment is N-bit, and the wrap is by comparison against CHANNELS-1, not by natural overflow.

## Timing
- Latency from EN, MODE or A to D, SEL and STEP is 1 cycle; inputs are sampled on the rising edge.
- No combinational input-to-output path; D, SEL and STEP are all flops.
- In steady SCAN, D changes exactly every PRESCALE cycles, and STEP is high in the cycle of each change.
- After a SCAN entry, the first advance happens PRESCALE cycles after the entry edge.
- Reset takes effect with no dependence on CLK; release must be synchronous to CLK (upstream responsibility).

## Structure
- Shared package dec_pkg holds:
  - state enum dec_state_t (IDLE, DIRECT, SCAN);
  - mode constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
- Sub-module onehot_dec: combinational, parameters N and CHANNELS, input idx[N-1:0], output oh[2^N-1:0], all-zero when idx ≥ CHANNELS.
- ACTIVE_LOW inversion is applied in dec_scan_n at the register input.
- Reused by both DIRECT and SCAN datapaths.

## Test plan
- Reset: with N=2, PRESCALE=2, ACTIVE_LOW=0, assert RST mid-cycle → D=0000, SEL=0, STEP=0 immediately, with no clock edge.
- Direct: EN=1, MODE=0, A=0,1,2,3 → D=0001,0010,0100,1000, each 1 cycle after A. With CHANNELS=3 and A=3 → D=0000, SEL=3.
- Scan: CHANNELS=3, PRESCALE=2, switch EN=1, MODE=1 → D=0001 and STEP=1 on entry, then 0010 after 2 cycles, 0100 after 4, 0001 (wrap) after 6. STEP high only in those cycles.
- PRESCALE=1 scan with N=2 → D rotates 0001→0010→0100→1000→0001 every cycle, STEP constantly 1.
- Mode and enable changes:
  - Drop EN mid-scan at SEL=2 → next cycle D=0000 and SEL held at 2.
  - Re-enable in scan → D=0001, SEL=0, STEP=1.
  - Switch to MODE=0 with A=1 → D=0010 next cycle, STEP=0.
- ACTIVE_LOW=1 with N=2: direct A=2 → D=1011; reset and IDLE → D=1111.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and constants for the dec_scan_n decoder family.
//   dec_state_t : operating state (IDLE, DIRECT, SCAN)
//   MODE_DIRECT / MODE_SCAN : encodings of the MODE input
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational N-to-2^N one-hot decoder restricted to the used channels.
//   idx : index to decode
//   oh  : one-hot result, all zero when idx >= CHANNELS
module onehot_dec #(
    parameter int unsigned N        = 2,
    parameter int unsigned CHANNELS = 2**N
) (
    input  logic [N-1:0]      idx,
    output logic [2**N-1:0]   oh
);

    always_comb begin
        oh = '0;
        // Only indices below CHANNELS can ever light a bit.
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (idx == N'(i)) begin
                oh[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_scan_n.sv
// Registered one-hot decoder with an autonomous scan mode for multiplexed
// display digits / channel selects.
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   EN   : block enable, 0 forces D inactive
//   MODE : 0 = direct decode of A, 1 = internal prescaled scan
//   A    : direct-mode index
//   D    : registered one-hot output (inverted when ACTIVE_LOW=1)
//   SEL  : index currently shown on D
//   STEP : one-cycle pulse when a new scan index first appears on D
module dec_scan_n
    import dec_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned CHANNELS   = 2**N,
    parameter int unsigned PRESCALE   = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            MODE,
    input  logic [N-1:0]    A,
    output logic [2**N-1:0] D,
    output logic            STEP,
    output logic [N-1:0]    SEL
);

    localparam int unsigned W  = 2**N;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [N-1:0]  SEL_LAST = N'(CHANNELS - 1);
    localparam logic [W-1:0]  D_OFF    = {W{ACTIVE_LOW}};

    dec_state_t    state_q, state_d;
    logic [N-1:0]  sel_q, sel_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          step_q, step_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  dec_oh;

    always_comb begin
        state_d = IDLE;
        sel_d   = sel_q;
        pre_d   = '0;
        step_d  = 1'b0;
        if (EN) begin
            if (MODE == MODE_DIRECT) begin
                state_d = DIRECT;
                sel_d   = A;
            end else begin
                state_d = SCAN;
                if (state_q != SCAN) begin
                    // Entry marks step 0 immediately.
                    sel_d  = '0;
                    step_d = 1'b1;
                end else if (pre_q == PRE_LAST) begin
                    sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                    step_d = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
        end
    end

    // sel_d is the index that D must show after the edge in both DIRECT and
    // SCAN, so one decoder serves both datapaths.
    onehot_dec #(
        .N        (N),
        .CHANNELS (CHANNELS)
    ) u_dec (
        .idx (sel_d),
        .oh  (dec_oh)
    );

    always_comb begin
        d_d = D_OFF;
        if (state_d != IDLE) begin
            d_d = ACTIVE_LOW ? ~dec_oh : dec_oh;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= '0;
            pre_q   <= '0;
            step_q  <= 1'b0;
            d_q     <= D_OFF;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pre_q   <= pre_d;
            step_q  <= step_d;
            d_q     <= d_d;
        end
    end

    assign D    = d_q;
    assign SEL  = sel_q;
    assign STEP = step_q;

endmodule
